gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port en, input, 1 bit: count enable; one step per clock while high.
REQ-005 SHALL have port up_dn, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port sat, input, 1 bit: mode; 1 = saturate at the ends, 0 = wrap around.
REQ-007 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 SHALL have port load_val, input, WIDTH bits: binary value taken when load=1.
REQ-009 SHALL have port gray_out, output, WIDTH bits: registered Gray-coded count that feeds the downstream Gray-to-binary stage.
REQ-010 SHALL have port bin_out, output, WIDTH bits: registered binary count, for bench checking only.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse on wrap-around.
REQ-012 SHALL have port at_limit, output, 1 bit: high while bin_out is all-ones with up_dn=1, or zero with up_dn=0.

Function
REQ-013 SHALL hold an internal binary count register B of width WIDTH.
REQ-014 SHALL compute next-state priority per clock edge as: load first, then en, then hold.
REQ-015 SHALL, when load=1, set B to load_val on the next edge, ignoring en, up_dn and sat.
REQ-016 SHALL, when en=1 and load=0 and up_dn=1, set B to B+1 modulo 2^WIDTH.
REQ-017 SHALL, when en=1 and load=0 and up_dn=0, set B to B-1 modulo 2^WIDTH.
REQ-018 SHALL, when sat=1, hold B at all-ones while counting up and at zero while counting down, with no wrap pulse.
REQ-019 SHALL register gray_out from the next-state value as Bnext XOR (Bnext >> 1), so that gray_out equals B XOR (B >> 1) in every cycle.
REQ-020 SHALL drive gray_out directly from a flop with no combinational path to the port, so the output is glitch-free.
REQ-021 SHALL change exactly one bit of gray_out per counting step, including at wrap-around.
REQ-022 SHALL produce a latency of one clock from en, load or load_val to the updated bin_out, gray_out and wrap.
REQ-023 SHALL register wrap high for exactly the cycle following a counting step from all-ones to 0 (up) or from 0 to all-ones (down).
REQ-024 SHALL NOT assert wrap on a load, even when the loaded value equals the wrapped value.
REQ-025 SHALL decode at_limit combinationally from bin_out and up_dn.
REQ-026 SHALL, when sat=0, still assert at_limit as an advance warning of wrap-around.
REQ-027 SHALL, when en=0 and load=0, hold all registers and return wrap to 0.
REQ-028 SHALL permit direction reversal on any cycle, with the reversed step taking effect on the next edge.

Reset
REQ-029 SHALL, on rst_n=0, immediately and without waiting for a clock edge, force B=0, gray_out=0, bin_out=0 and wrap=0.
REQ-030 SHALL drive at_limit from the reset values during reset: at_limit=1 if up_dn=0, else 0.
REQ-031 SHALL, after reset deasserts, take the first state update on the first rising clk edge with rst_n=1.
REQ-032 SHALL honour reset asserted mid-count or mid-load over any pending update.

Verification (WIDTH=4)
REQ-033 SHALL cover reset: pulse rst_n low between edges -> gray_out=0000, bin_out=0000 and wrap=0 at once, before the next clk edge.
REQ-034 SHALL cover free-run up: sat=0, up_dn=1, en=1 for 16 cycles -> gray_out steps 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000, with wrap=1 only in the 0000 cycle and one bit changing per step.
REQ-035 SHALL cover down from 0: up_dn=0, en=1 -> bin_out=1111, gray_out=1000, wrap=1 for one cycle; next cycle bin_out=1110, gray_out=1001, wrap=0.
REQ-036 SHALL cover load priority: load=1, load_val=0101 and en=1 in the same cycle -> next cycle bin_out=0101, gray_out=0111, wrap=0.
REQ-037 SHALL cover saturate: sat=1, load 1111, then up_dn=1, en=1 for 3 cycles -> gray_out stays 1000, at_limit=1, wrap never asserts.
REQ-038 SHALL cover async reset mid-count: rst_n low at bin_out=1010 -> outputs 0 immediately; after release with en=1 -> gray_out 0001 on the first edge.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with optional saturation, synchronous load and a wrap pulse.
// gray_out comes straight from a flop so downstream sampling never sees glitches.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_reg;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             at_top;
    logic             at_bottom;

    assign at_top    = (bin_reg == ALL_ONES);
    assign at_bottom = (bin_reg == ZERO);

    // Priority: load, then count, then hold. Loads never raise wrap.
    always_comb begin
        bin_next  = bin_reg;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_val;
        end else if (en) begin
            if (up_dn) begin
                if (at_top) begin
                    if (!sat) begin
                        bin_next  = ZERO;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_reg + ONE;
                end
            end else begin
                if (at_bottom) begin
                    if (!sat) begin
                        bin_next  = ALL_ONES;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_reg - ONE;
                end
            end
        end
    end

    // Gray encoding of the next state, so the registered Gray value tracks bin_reg exactly.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
        end
    endgenerate
    assign gray_next[WIDTH-1] = bin_next[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg  <= ZERO;
            gray_reg <= ZERO;
            wrap_reg <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            wrap_reg <= wrap_next;
        end
    end

    assign bin_out  = bin_reg;
    assign gray_out = gray_reg;
    assign wrap     = wrap_reg;
    assign at_limit = up_dn ? at_top : at_bottom;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter (WIDTH=4): reset, free-run, down-wrap, load, saturate, reversal.
`timescale 1ns/1ps
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       sat;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] gray_out;
    logic [3:0] bin_out;
    logic       wrap;
    logic       at_limit;

    int compared   = 0;
    int mismatched = 0;

    gray_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .gray_out (gray_out),
        .bin_out  (bin_out),
        .wrap     (wrap),
        .at_limit (at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] b, input logic [3:0] g, input logic w);
        check({tag, "_bin"}, {12'd0, bin_out}, {12'd0, b});
        check({tag, "_gray"}, {12'd0, gray_out}, {12'd0, g});
        check({tag, "_wrap"}, {15'd0, wrap}, {15'd0, w});
        $display("%s: bin=%b gray=%b wrap=%b at_limit=%b", tag, bin_out, gray_out, wrap, at_limit);
    endtask

    logic [3:0] gseq [17];
    logic [3:0] prev_gray;

    initial begin
        gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

        rst_n = 1'b1; en = 1'b0; up_dn = 1'b1; sat = 1'b0; load = 1'b0; load_val = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        // Reset takes effect before any clock edge.
        check_state("reset_async", 4'b0000, 4'b0000, 1'b0);
        check("reset_at_limit_up", {15'd0, at_limit}, 16'd0);
        up_dn = 1'b0;
        #1;
        check("reset_at_limit_dn", {15'd0, at_limit}, 16'd1);
        up_dn = 1'b1;

        step();
        rst_n = 1'b1;
        check_state("post_release", 4'b0000, 4'b0000, 1'b0);

        // Free-run up through a full wrap.
        en = 1'b1; up_dn = 1'b1; sat = 1'b0;
        prev_gray = gray_out;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_state($sformatf("up_%0d", i), 4'(i), gseq[i], (i == 16));
            check($sformatf("up_onebit_%0d", i), 16'($countones(gray_out ^ prev_gray)), 16'd1);
            check($sformatf("up_at_limit_%0d", i), {15'd0, at_limit}, {15'd0, (i == 15)});
            prev_gray = gray_out;
        end

        // Down from zero wraps to all-ones.
        up_dn = 1'b0;
        step();
        check_state("down_wrap", 4'b1111, 4'b1000, 1'b1);
        step();
        check_state("down_next", 4'b1110, 4'b1001, 1'b0);

        // Hold.
        en = 1'b0;
        step();
        check_state("hold", 4'b1110, 4'b1001, 1'b0);

        // Load wins over enable.
        en = 1'b1; load = 1'b1; load_val = 4'b0101;
        step();
        check_state("load_prio", 4'b0101, 4'b0111, 1'b0);

        // Loading the wrapped value from all-ones must not pulse wrap.
        load_val = 4'b1111;
        step();
        load_val = 4'b0000;
        step();
        check_state("load_no_wrap", 4'b0000, 4'b0000, 1'b0);

        // Saturate at top.
        sat = 1'b1; load_val = 4'b1111;
        step();
        load = 1'b0; up_dn = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("sat_up_%0d", i), 4'b1111, 4'b1000, 1'b0);
            check($sformatf("sat_up_limit_%0d", i), {15'd0, at_limit}, 16'd1);
        end

        // Saturate at bottom.
        load = 1'b1; load_val = 4'b0000;
        step();
        load = 1'b0; up_dn = 1'b0;
        step();
        check_state("sat_dn", 4'b0000, 4'b0000, 1'b0);
        check("sat_dn_limit", {15'd0, at_limit}, 16'd1);

        // Direction reversal takes effect on the next edge.
        sat = 1'b0; load = 1'b1; load_val = 4'b0011;
        step();
        load = 1'b0; up_dn = 1'b1;
        step();
        check_state("rev_up", 4'b0100, 4'b0110, 1'b0);
        up_dn = 1'b0;
        step();
        check_state("rev_dn", 4'b0011, 4'b0010, 1'b0);

        // Async reset mid-count at 1010.
        load = 1'b1; load_val = 4'b1010;
        step();
        load = 1'b0; up_dn = 1'b1; en = 1'b1;
        check_state("pre_reset", 4'b1010, 4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("mid_reset", 4'b0000, 4'b0000, 1'b0);
        step();
        rst_n = 1'b1;
        check_state("reset_held", 4'b0000, 4'b0000, 1'b0);
        step();
        check_state("after_reset", 4'b0001, 4'b0001, 1'b0);

        // Reset overrides a pending load.
        load = 1'b1; load_val = 4'b1001;
        rst_n = 1'b0;
        step();
        check_state("reset_over_load", 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step();
        check_state("load_after_reset", 4'b1001, 4'b1101, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
